// File: rtl/uart_rx_fifo.sv
// UART receiver (x16 oversampled, 3-sample majority) feeding a show-ahead receive FIFO.
// An entry is pushed on the final stop-bit decision and appears one clk later; if the FIFO is full it is dropped and o_overrun is flagged.
module uart_rx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_baud_x16,
  input  logic [1:0]                    i_parity_mode,
  input  logic                          i_stop2,
  input  logic                          i_RX,
  output logic [DATA_WIDTH-1:0]         o_dout,
  output logic [2:0]                    o_error,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_overrun,
  input  logic                          i_clr_overrun,
  output logic                          o_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + 3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;
  localparam logic [2:0] S_BRK    = 3'd6;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_prev_q, rx_prev_d;
  logic [2:0]             state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   s7_q, s7_d, s8_q, s8_d;
  logic [3:0]             bit_q, bit_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [1:0]             pmode_q, pmode_d;
  logic                   stop2_q, stop2_d;
  logic                   par_err_q, par_err_d;
  logic                   par_bit_q, par_bit_d;

  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   overrun_q, overrun_d;
  logic [EW-1:0]          mem_q [FIFO_DEPTH];

  logic rx_s, maj, decide, par_en;
  logic push, push_fe, push_brk;
  logic pop, full, wr_en;
  logic [EW-1:0] head;

  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign maj    = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);
  assign decide = i_baud_x16 && (cnt_q == 4'd9);
  assign par_en = pmode_q[0] ^ pmode_q[1];

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], i_RX};
    rx_prev_d = rx_s;
    state_d   = state_q;
    cnt_d     = cnt_q;
    s7_d      = s7_q;
    s8_d      = s8_q;
    bit_d     = bit_q;
    data_d    = data_q;
    pmode_d   = pmode_q;
    stop2_d   = stop2_q;
    par_err_d = par_err_q;
    par_bit_d = par_bit_q;
    push      = 1'b0;
    push_fe   = 1'b0;
    push_brk  = 1'b0;

    if (i_baud_x16) begin
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd7) s7_d = rx_s;
      if (cnt_q == 4'd8) s8_d = rx_s;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d = S_START;
          cnt_d   = 4'd0;
        end
      end
      S_START: begin
        if (decide) begin
          if (!maj) begin
            state_d   = S_DATA;
            bit_d     = 4'd0;
            pmode_d   = i_parity_mode;
            stop2_d   = i_stop2;
            par_err_d = 1'b0;
            par_bit_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (decide) begin
          data_d = {maj, data_q[DATA_WIDTH-1:1]};
          bit_d  = bit_q + 4'd1;
          if (bit_q == 4'(DATA_WIDTH - 1)) state_d = par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (decide) begin
          par_bit_d = maj;
          // Odd mode expects data^p == 1, even mode expects 0; pmode_q[1] selects odd.
          par_err_d = ((^data_q) ^ maj) != pmode_q[1];
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (decide) begin
          if (maj && stop2_q) begin
            state_d = S_STOP2;
          end else begin
            push     = 1'b1;
            push_fe  = !maj;
            push_brk = !maj && (data_q == '0) && (!par_en || !par_bit_q);
            state_d  = maj ? S_IDLE : S_BRK;
          end
        end
      end
      S_STOP2: begin
        if (decide) begin
          push    = 1'b1;
          push_fe = !maj;
          state_d = maj ? S_IDLE : S_BRK;
        end
      end
      S_BRK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    full      = (count_q == CW'(FIFO_DEPTH));
    pop       = (count_q != '0) && i_ready;
    wr_en     = push && (!full || pop);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_en && !pop) count_d = count_q + CW'(1);
    if (!wr_en && pop) count_d = count_q - CW'(1);
    // A new overrun outranks a simultaneous clear.
    if (push && full && !pop) overrun_d = 1'b1;
    else if (i_clr_overrun)   overrun_d = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      s7_q      <= 1'b1;
      s8_q      <= 1'b1;
      bit_q     <= '0;
      data_q    <= '0;
      pmode_q   <= '0;
      stop2_q   <= 1'b0;
      par_err_q <= 1'b0;
      par_bit_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      rx_prev_q <= rx_prev_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s7_q      <= s7_d;
      s8_q      <= s8_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      pmode_q   <= pmode_d;
      stop2_q   <= stop2_d;
      par_err_q <= par_err_d;
      par_bit_q <= par_bit_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {push_brk, par_err_q, push_fe, data_q};
  end

  assign head      = mem_q[rd_ptr_q];
  assign o_valid   = (count_q != '0);
  assign o_dout    = o_valid ? head[DATA_WIDTH-1:0] : '0;
  assign o_error   = o_valid ? head[EW-1:DATA_WIDTH] : 3'b000;
  assign o_count   = count_q;
  assign o_overrun = overrun_q;
  assign o_busy    = (state_q != S_IDLE);
endmodule
